vend_ctrl: RTL

Transaction controller for the coin-operated vending datapath. It accepts coins over a valid/ready handshake and accumulates credit against a parameterised price. It then sequences an external product dispenser over a req/ack handshake and pays out change or refunds one unit per cycle. Cancel and an inactivity timeout both trigger a full refund. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit accumulation, dispenser req/ack
// sequencing, and one-unit-per-cycle change or refund payout.
module vend_ctrl #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                product,
    output logic                change_pulse,
    output logic                refunding,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [2:0]          fsm_state
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [TW-1:0]       TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        REFUND   = 3'd4
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [TW-1:0]       idle_cnt;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] credit_sum;
    logic                accept;
    logic                coin_ok;
    logic                coin_bad;
    logic                timed_out;

    // Handshake: a coin transfers on any edge where coin_valid and coin_ready are both high.
    assign coin_ready   = (state_q == IDLE) || (state_q == COLLECT);
    assign accept       = coin_valid & coin_ready;
    assign coin_ok      = accept & (coin_code != 2'd3);
    assign coin_bad     = accept & (coin_code == 2'd3);
    assign credit_sum   = credit_q + (coin_ok ? coin_value : '0);
    assign timed_out    = (state_q == COLLECT) && !coin_ok && (idle_cnt == TO_LAST);

    assign disp_req     = (state_q == DISPENSE);
    assign change_pulse = (state_q == CHANGE) || (state_q == REFUND);
    assign refunding    = (state_q == REFUND);
    assign busy         = (state_q != IDLE);
    assign credit       = credit_q;
    assign fsm_state    = state_q;

    always_comb begin
        coin_value = '0;
        case (coin_code)
            2'd0:    coin_value = CREDIT_W'(1);
            2'd1:    coin_value = CREDIT_W'(2);
            2'd2:    coin_value = CREDIT_W'(5);
            default: coin_value = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            idle_cnt    <= '0;
            coin_reject <= 1'b0;
            product     <= 1'b0;
        end else begin
            coin_reject <= coin_bad;
            product     <= 1'b0;
            case (state_q)
                IDLE, COLLECT: begin
                    credit_q <= credit_sum;
                    if (coin_ok || state_q == IDLE)
                        idle_cnt <= '0;
                    else
                        idle_cnt <= idle_cnt + TW'(1);
                    // Cancel outranks dispense; an accompanying coin is already in credit_sum.
                    if (cancel && credit_sum != '0)
                        state_q <= REFUND;
                    else if (credit_sum >= PRICE_C)
                        state_q <= DISPENSE;
                    else if (timed_out)
                        state_q <= REFUND;
                    else if (coin_ok)
                        state_q <= COLLECT;
                end
                DISPENSE: begin
                    idle_cnt <= '0;
                    if (disp_ack) begin
                        credit_q <= credit_q - PRICE_C;
                        product  <= 1'b1;
                        state_q  <= (credit_q != PRICE_C) ? CHANGE : IDLE;
                    end
                end
                CHANGE, REFUND: begin
                    idle_cnt <= '0;
                    credit_q <= credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1))
                        state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    credit_q <= '0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule
